// File: rtl/payload_engine_pkg.sv
// rtl/payload_engine_pkg.sv - shared constants, types and parameter-slicing helper for payload engines
package payload_engine_pkg;

  localparam int MAX_STATES = 64;
  localparam int MAX_VEC    = MAX_STATES * MAX_STATES;
  localparam int DEF_OFF_W  = 16;
  localparam int DEF_CNT_W  = 8;
  localparam int DEF_CLS_W  = 7;

  typedef logic [DEF_CLS_W-1:0] cls_idx_t;

  // Return field idx of width w from a packed parameter vector, zero-extended.
  function automatic logic [MAX_STATES-1:0] get_field(input logic [MAX_VEC-1:0] vec,
                                                      input int idx,
                                                      input int w);
    logic [MAX_VEC-1:0]    sh;
    logic [MAX_STATES-1:0] mask;
    sh   = vec >> (idx * w);
    mask = (w >= MAX_STATES) ? '1 : ((MAX_STATES'(1) << w) - MAX_STATES'(1));
    return sh[MAX_STATES-1:0] & mask;
  endfunction

endpackage

// File: rtl/nfa_state_cell.sv
// rtl/nfa_state_cell.sv - one NFA position: feed logic plus its registered state bit
module nfa_state_cell
  import payload_engine_pkg::*;
#(
  parameter int N_STATES = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sod,
  input  logic                en,
  input  logic                class_bit,
  input  logic [N_STATES-1:0] pred_vec,
  input  logic                start_feed,
  output logic                nxt,
  output logic                state
);

  // On sod the predecessors belong to the old packet, so only the start feed counts.
  assign nxt = class_bit & (((|pred_vec) & ~sod) | start_feed);

  // Advance on a valid byte; a bare sod restarts the position from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= 1'b0;
    end else if (en) begin
      state <= nxt;
    end else if (sod) begin
      state <= 1'b0;
    end
  end

endmodule

// File: rtl/param_nfa_engine.sv
// rtl/param_nfa_engine.sv - parametrised one-hot NFA payload matcher with match statistics
module param_nfa_engine
  import payload_engine_pkg::*;
#(
  parameter int                           N_STATES    = 8,
  parameter int                           N_CLASS     = 128,
  parameter int                           CLS_W       = 7,
  parameter logic [N_STATES*CLS_W-1:0]    STATE_CLASS = '0,
  parameter logic [N_STATES*N_STATES-1:0] PRED_MASK   = '0,
  parameter logic [N_STATES-1:0]          START_MASK  = 'b1,
  parameter logic [N_STATES-1:0]          ACCEPT_MASK = 'b0,
  parameter bit                           ANCHORED    = 1'b0,
  parameter int                           OFF_W       = DEF_OFF_W,
  parameter int                           CNT_W       = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sod,
  input  logic                en,
  input  logic [N_CLASS-1:0]  class_hit,
  output logic                match,
  output logic                match_pulse,
  output logic [OFF_W-1:0]    match_offset,
  output logic [CNT_W-1:0]    match_cnt,
  output logic [N_STATES-1:0] state_vec
);

  localparam logic [MAX_VEC-1:0] CLASS_VEC = MAX_VEC'(STATE_CLASS);
  localparam logic [MAX_VEC-1:0] PRED_VEC  = MAX_VEC'(PRED_MASK);

  if (ACCEPT_MASK == '0) begin : g_no_accept
    $error("param_nfa_engine: ACCEPT_MASK is empty, the rule can never match");
  end

  logic                first_byte;
  logic [OFF_W-1:0]    off_cnt;
  logic [N_STATES-1:0] nxt;
  logic                hit;

  // A sod arriving with a byte makes that byte offset 0 of a fresh packet.
  logic                first_eff;
  logic [OFF_W-1:0]    off_eff;
  logic                match_eff;
  logic [CNT_W-1:0]    cnt_eff;
  logic [OFF_W-1:0]    moff_eff;

  assign first_eff = first_byte | sod;
  assign off_eff   = sod ? '0 : off_cnt;
  assign match_eff = match & ~sod;
  assign cnt_eff   = sod ? '0 : match_cnt;
  assign moff_eff  = sod ? '0 : match_offset;

  logic unused_class_hit;
  assign unused_class_hit = ^class_hit;

  for (genvar i = 0; i < N_STATES; i++) begin : g_state
    localparam int                  CLS_I  = int'(get_field(CLASS_VEC, i, CLS_W));
    localparam logic [N_STATES-1:0] PRED_I = N_STATES'(get_field(PRED_VEC, i, N_STATES));

    logic class_bit;
    logic start_feed;

    if (CLS_I >= N_CLASS) begin : g_bad_class
      $error("param_nfa_engine: state %0d uses class %0d beyond N_CLASS", i, CLS_I);
      assign class_bit = 1'b0;
    end else begin : g_class
      assign class_bit = class_hit[CLS_I];
    end

    assign start_feed = START_MASK[i] & (~ANCHORED | first_eff);

    nfa_state_cell #(
      .N_STATES (N_STATES)
    ) u_cell (
      .clk        (clk),
      .rst        (rst),
      .sod        (sod),
      .en         (en),
      .class_bit  (class_bit),
      .pred_vec   (state_vec & PRED_I),
      .start_feed (start_feed),
      .nxt        (nxt[i]),
      .state      (state_vec[i])
    );
  end

  assign hit = en & (|(nxt & ACCEPT_MASK));

  // Packet bookkeeping: byte offset, first-byte flag and registered match results.
  always_ff @(posedge clk) begin
    if (rst) begin
      first_byte   <= 1'b1;
      off_cnt      <= '0;
      match        <= 1'b0;
      match_pulse  <= 1'b0;
      match_offset <= '0;
      match_cnt    <= '0;
    end else if (en) begin
      first_byte   <= 1'b0;
      off_cnt      <= (&off_eff) ? off_eff : off_eff + OFF_W'(1);
      match_pulse  <= hit;
      match        <= match_eff | hit;
      match_offset <= (hit && !match_eff) ? off_eff : moff_eff;
      match_cnt    <= (hit && !(&cnt_eff)) ? cnt_eff + CNT_W'(1) : cnt_eff;
    end else begin
      match_pulse <= 1'b0;
      if (sod) begin
        first_byte   <= 1'b1;
        off_cnt      <= '0;
        match        <= 1'b0;
        match_offset <= '0;
        match_cnt    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_param_nfa_engine.sv
// tb/tb_param_nfa_engine.sv - bench for param_nfa_engine on pattern ab.*c in three configurations
module tb_param_nfa_engine;

  localparam logic [7:0]  SC  = 8'b11_10_01_00;
  localparam logic [15:0] PM  = 16'h6610;
  localparam logic [3:0]  STM = 4'b0001;
  localparam logic [3:0]  ACM = 4'b1000;

  logic       clk = 1'b0;
  logic       rst;
  logic       sod;
  logic       en;
  logic [3:0] class_hit;

  always #5 clk = ~clk;

  logic        u_m, u_p, a_m, a_p, s_m, s_p;
  logic [15:0] u_off, a_off;
  logic [2:0]  s_off;
  logic [7:0]  u_cnt, a_cnt;
  logic [1:0]  s_cnt;
  logic [3:0]  u_sv, a_sv, s_sv;

  param_nfa_engine #(.N_STATES(4), .N_CLASS(4), .CLS_W(2), .STATE_CLASS(SC), .PRED_MASK(PM),
    .START_MASK(STM), .ACCEPT_MASK(ACM), .ANCHORED(1'b0), .OFF_W(16), .CNT_W(8)) u_unanch (
    .clk(clk), .rst(rst), .sod(sod), .en(en), .class_hit(class_hit), .match(u_m),
    .match_pulse(u_p), .match_offset(u_off), .match_cnt(u_cnt), .state_vec(u_sv));

  param_nfa_engine #(.N_STATES(4), .N_CLASS(4), .CLS_W(2), .STATE_CLASS(SC), .PRED_MASK(PM),
    .START_MASK(STM), .ACCEPT_MASK(ACM), .ANCHORED(1'b1), .OFF_W(16), .CNT_W(8)) u_anch (
    .clk(clk), .rst(rst), .sod(sod), .en(en), .class_hit(class_hit), .match(a_m),
    .match_pulse(a_p), .match_offset(a_off), .match_cnt(a_cnt), .state_vec(a_sv));

  param_nfa_engine #(.N_STATES(4), .N_CLASS(4), .CLS_W(2), .STATE_CLASS(SC), .PRED_MASK(PM),
    .START_MASK(STM), .ACCEPT_MASK(ACM), .ANCHORED(1'b0), .OFF_W(3), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .sod(sod), .en(en), .class_hit(class_hit), .match(s_m),
    .match_pulse(s_p), .match_offset(s_off), .match_cnt(s_cnt), .state_vec(s_sv));

  logic        act_m[3];
  logic        act_p[3];
  logic [15:0] act_off[3];
  logic [7:0]  act_cnt[3];
  logic [3:0]  act_sv[3];

  assign act_m[0] = u_m;  assign act_m[1] = a_m;  assign act_m[2] = s_m;
  assign act_p[0] = u_p;  assign act_p[1] = a_p;  assign act_p[2] = s_p;
  assign act_off[0] = u_off; assign act_off[1] = a_off; assign act_off[2] = {13'b0, s_off};
  assign act_cnt[0] = u_cnt; assign act_cnt[1] = a_cnt; assign act_cnt[2] = {6'b0, s_cnt};
  assign act_sv[0] = u_sv; assign act_sv[1] = a_sv; assign act_sv[2] = s_sv;

  int n_total  = 0;
  int n_passed = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else n_passed++;
  endfunction

  function automatic logic [3:0] cls(byte unsigned b);
    return {b == "c", 1'b1, b == "b", b == "a"};
  endfunction

  typedef struct {
    bit          sod;
    bit          en;
    byte unsigned ch;
    bit          um;
    bit          up;
    int          uoff;
    int          ucnt;
    bit          am;
    int          aoff;
    int          soff;
    int          scnt;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit sd, bit e, byte unsigned c, bit um, bit up, int uoff, int ucnt,
                              bit am, int aoff, int soff, int scnt);
    vec_t v;
    v.sod = sd; v.en = e; v.ch = c; v.um = um; v.up = up; v.uoff = uoff; v.ucnt = ucnt;
    v.am = am; v.aoff = aoff; v.soff = soff; v.scnt = scnt;
    tbl.push_back(v);
  endfunction

  function automatic void z(bit sd, bit e, byte unsigned c);
    add(sd, e, c, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  // Reference model: the packet's accepted bytes and the regex ab.*c evaluated over them.
  byte unsigned pkt[$];
  bit           anch[3]   = '{1'b0, 1'b1, 1'b0};
  int           offmax[3] = '{65535, 65535, 7};
  int           cntmax[3] = '{255, 255, 3};
  int           m_m[3], m_p[3], m_off[3], m_cnt[3];
  logic [3:0]   m_sv[3];

  function automatic void model_clear();
    pkt.delete();
    for (int d = 0; d < 3; d++) begin
      m_m[d] = 0; m_p[d] = 0; m_off[d] = 0; m_cnt[d] = 0; m_sv[d] = 4'b0;
    end
  endfunction

  function automatic void model_step(bit r, bit sd, bit e, byte unsigned b);
    int k;
    bit started, hit;
    if (r || (sd && !e)) begin
      model_clear();
    end else if (e) begin
      if (sd) model_clear();
      pkt.push_back(b);
      k = pkt.size() - 1;
      for (int d = 0; d < 3; d++) begin
        started = 0;
        for (int s = 0; s + 2 <= k; s++)
          if ((!anch[d] || s == 0) && pkt[s] == "a" && pkt[s+1] == "b") started = 1;
        m_sv[d][0] = (pkt[k] == "a") && (!anch[d] || k == 0);
        m_sv[d][1] = (k >= 1) && (pkt[k] == "b") && (pkt[k-1] == "a") && (!anch[d] || k == 1);
        m_sv[d][2] = started;
        hit        = started && (pkt[k] == "c");
        m_sv[d][3] = hit;
        m_p[d]     = hit;
        if (hit && m_m[d] == 0) m_off[d] = (k > offmax[d]) ? offmax[d] : k;
        if (hit) begin
          m_m[d]   = 1;
          m_cnt[d] = (m_cnt[d] < cntmax[d]) ? m_cnt[d] + 1 : m_cnt[d];
        end
      end
    end else begin
      for (int d = 0; d < 3; d++) m_p[d] = 0;
    end
  endfunction

  task automatic apply(bit r, bit sd, bit e, byte unsigned b);
    rst = r; sod = sd; en = e; class_hit = cls(b);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sel;
    byte unsigned b;
    bit r, sd, e;

    rst = 1'b1; sod = 1'b0; en = 1'b0; class_hit = 4'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_match[%0d]", d), 32'(act_m[d]), 0);
      chk($sformatf("reset_pulse[%0d]", d), 32'(act_p[d]), 0);
      chk($sformatf("reset_off[%0d]", d), 32'(act_off[d]), 0);
      chk($sformatf("reset_cnt[%0d]", d), 32'(act_cnt[d]), 0);
      chk($sformatf("reset_sv[%0d]", d), 32'(act_sv[d]), 0);
    end

    // "xxabzzc" unanchored hit at offset 6
    z(1, 1, "x"); z(0, 1, "x"); z(0, 1, "a"); z(0, 1, "b"); z(0, 1, "z"); z(0, 1, "z");
    add(0, 1, "c", 1, 1, 6, 1, 0, 0, 6, 1);
    add(0, 0, "x", 1, 0, 6, 1, 0, 0, 6, 1);
    // "abcc" two hits
    z(1, 1, "a"); z(0, 1, "b");
    add(0, 1, "c", 1, 1, 2, 1, 1, 2, 2, 1);
    add(0, 1, "c", 1, 1, 2, 2, 1, 2, 2, 2);
    // "xab c" misses when anchored, then a fresh "abc"
    z(1, 1, "x"); z(0, 1, "a"); z(0, 1, "b"); z(0, 1, " ");
    add(0, 1, "c", 1, 1, 4, 1, 0, 0, 4, 1);
    z(1, 1, "a"); z(0, 1, "b");
    add(0, 1, "c", 1, 1, 2, 1, 1, 2, 2, 1);
    // en gaps between bytes
    z(1, 1, "a");
    for (int j = 0; j < 5; j++) z(0, 0, "c");
    z(0, 1, "b");
    add(0, 1, "c", 1, 1, 2, 1, 1, 2, 2, 1);
    add(0, 0, "c", 1, 0, 2, 1, 1, 2, 2, 1);
    // match counter saturation
    z(1, 1, "a"); z(0, 1, "b");
    for (int j = 1; j <= 6; j++) add(0, 1, "c", 1, 1, 2, j, 1, 2, 2, (j > 3) ? 3 : j);
    // offset saturation: match completes at byte 9
    z(1, 1, "x");
    for (int j = 0; j < 6; j++) z(0, 1, "x");
    z(0, 1, "a"); z(0, 1, "b");
    add(0, 1, "c", 1, 1, 9, 1, 0, 0, 7, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(0, tbl[i].sod, tbl[i].en, tbl[i].ch);
      chk($sformatf("vec%0d_u_match", i), 32'(u_m), 32'(tbl[i].um));
      chk($sformatf("vec%0d_u_pulse", i), 32'(u_p), 32'(tbl[i].up));
      chk($sformatf("vec%0d_u_off", i), 32'(u_off), tbl[i].uoff);
      chk($sformatf("vec%0d_u_cnt", i), 32'(u_cnt), tbl[i].ucnt);
      chk($sformatf("vec%0d_a_match", i), 32'(a_m), 32'(tbl[i].am));
      chk($sformatf("vec%0d_a_off", i), 32'(a_off), tbl[i].aoff);
      chk($sformatf("vec%0d_s_off", i), 32'(s_off), tbl[i].soff);
      chk($sformatf("vec%0d_s_cnt", i), 32'(s_cnt), tbl[i].scnt);
    end

    // rst in the middle of a match clears everything and forgets "ab"
    apply(0, 1, 1, "a");
    apply(0, 0, 1, "b");
    chk("mid_sv_after_ab", 32'(u_sv), 32'(4'b0010));
    apply(1, 0, 0, "x");
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("midrst_match[%0d]", d), 32'(act_m[d]), 0);
      chk($sformatf("midrst_off[%0d]", d), 32'(act_off[d]), 0);
      chk($sformatf("midrst_cnt[%0d]", d), 32'(act_cnt[d]), 0);
      chk($sformatf("midrst_sv[%0d]", d), 32'(act_sv[d]), 0);
    end
    apply(0, 0, 1, "c");
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("lone_c_match[%0d]", d), 32'(act_m[d]), 0);
      chk($sformatf("lone_c_pulse[%0d]", d), 32'(act_p[d]), 0);
      chk($sformatf("lone_c_sv[%0d]", d), 32'(act_sv[d]), 0);
    end
    apply(0, 1, 1, "a");
    for (int d = 0; d < 3; d++)
      chk($sformatf("sod_a_sv[%0d]", d), 32'(act_sv[d]), 32'(4'b0001));

    // randomized traffic against the model
    apply(1, 0, 0, "x");
    model_step(1, 0, 0, "x");
    for (int cyc = 0; cyc < 3000; cyc++) begin
      r  = ($urandom_range(0, 299) == 0);
      sd = ($urandom_range(0, 29) == 0);
      e  = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 9);
      b = (sel < 3) ? "a" : (sel < 6) ? "b" : (sel < 8) ? "c" : "x";
      apply(r, sd, e, b);
      model_step(r, sd, e, b);
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("rnd%0d_match[%0d]", cyc, d), 32'(act_m[d]), m_m[d]);
        chk($sformatf("rnd%0d_pulse[%0d]", cyc, d), 32'(act_p[d]), m_p[d]);
        chk($sformatf("rnd%0d_off[%0d]", cyc, d), 32'(act_off[d]), m_off[d]);
        chk($sformatf("rnd%0d_cnt[%0d]", cyc, d), 32'(act_cnt[d]), m_cnt[d]);
        chk($sformatf("rnd%0d_sv[%0d]", cyc, d), 32'(act_sv[d]), 32'(m_sv[d]));
      end
    end

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
